// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: byte FIFO plus framing FSM that feeds one message to the
// hasher, waits for its digest (or times out) and hands the result back.
//
// Handshakes (cmd_*, in_*, res_*): a transfer happens on a rising clk edge
// where valid and ready are both high. Valid never depends on ready, and a
// source holding valid keeps its payload stable until that edge.
module hash_msg_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        M_valid,
    output logic [7:0]  M,
    output logic [63:0] C_in,
    input  logic        hash_ready,
    input  logic [31:0] digest_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_digest,
    output logic        res_err,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMPTY,
        S_STREAM,
        S_GUARD,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       rem_q, rem_d;
    logic [63:0]       c_in_q, c_in_d;
    logic              guard_q, guard_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [31:0]       res_digest_q, res_digest_d;
    logic              res_err_q, res_err_d;
    logic              m_valid_q, m_valid_d;
    logic [7:0]        m_q, m_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (count_q == '0);
    // Holding in_ready low during reset keeps the flush from racing a push.
    assign in_ready   = !rst && (count_q != CNT_FULL);
    assign push       = in_valid && in_ready;

    assign cmd_ready  = !rst && (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = (state_q == S_RESULT);
    assign res_digest = res_digest_q;
    assign res_err    = res_err_q;
    assign M_valid    = m_valid_q;
    assign M          = m_q;
    assign C_in       = c_in_q;
    assign state_dbg  = state_q;

    // Byte storage; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Framing FSM: next state, pop request and registered hasher/result outputs.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        c_in_d       = c_in_q;
        guard_d      = guard_q;
        timer_d      = timer_q;
        res_digest_d = res_digest_q;
        res_err_d    = res_err_q;
        m_valid_d    = 1'b0;
        m_d          = m_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    c_in_d  = cmd_len;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == 64'd0) ? S_EMPTY : S_STREAM;
                end
            end
            S_EMPTY: begin
                // A zero-length message is still announced with one strobe.
                m_valid_d = 1'b1;
                m_d       = 8'h00;
                guard_d   = 1'b0;
                state_d   = S_GUARD;
            end
            S_STREAM: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    m_valid_d = 1'b1;
                    m_d       = mem_q[rd_ptr_q];
                    rem_d     = rem_q - 64'd1;
                    if (rem_q == 64'd1) begin
                        guard_d = 1'b0;
                        state_d = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                // Two dead cycles so a ready left high by the last message is ignored.
                if (guard_q) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    guard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (hash_ready) begin
                    res_digest_d = digest_in;
                    res_err_d    = 1'b0;
                    state_d      = S_RESULT;
                end else if (timer_q == TMR_MAX) begin
                    res_digest_d = 32'd0;
                    res_err_d    = 1'b1;
                    state_d      = S_RESULT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= 64'd0;
            c_in_q       <= 64'd0;
            guard_q      <= 1'b0;
            timer_q      <= '0;
            res_digest_q <= 32'd0;
            res_err_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_q          <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            c_in_q       <= c_in_d;
            guard_q      <= guard_d;
            timer_q      <= timer_d;
            res_digest_q <= res_digest_d;
            res_err_q    <= res_err_d;
            m_valid_q    <= m_valid_d;
            m_q          <= m_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: byte producer process, hasher stub inside the
// message task, and a reference model built from the accepted byte history.
module tb_hash_msg_feeder;

    localparam int DEPTH = 16;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_len;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        M_valid;
    logic [7:0]  M;
    logic [63:0] C_in;
    logic        hash_ready;
    logic [31:0] digest_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_digest;
    logic        res_err;
    logic        busy;
    logic [2:0]  state_dbg;

    hash_msg_feeder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .M_valid(M_valid), .M(M), .C_in(C_in),
        .hash_ready(hash_ready), .digest_in(digest_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_digest(res_digest), .res_err(res_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every accepted byte in order; messages consume from hist_ptr.
    logic [7:0] hist[$];
    int         hist_ptr = 0;

    // Producer state.
    logic [7:0] src_q[$];
    logic       gap_mode = 1'b0;
    int         phase = 0;
    logic       hs_prev = 1'b0;

    // Per-message observations.
    logic [7:0]  got_q[$];
    logic [7:0]  t3_q[$];
    int          cin_bad;
    int          res_n;
    int          first_mv;
    int          last_mv;
    logic [31:0] r_dig;
    logic        r_err;

    always @(posedge clk) begin
        if (rst) hist.delete();
        else if (in_valid && in_ready) hist.push_back(in_data);
        hs_prev <= !rst && in_valid && in_ready;
    end

    always @(negedge clk) begin
        if (hs_prev && src_q.size() > 0) void'(src_q.pop_front());
        phase = (phase + 1) % 3;
        if (src_q.size() > 0 && (!gap_mode || phase == 0)) begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end else begin
            in_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // hr_delay: >=0 raise hash_ready that many cycles after the last strobe,
    // -1 never answer, -2 hold hash_ready high from the start.
    task automatic run_msg(input logic [63:0] len, input int hr_delay,
                           input logic [31:0] dig, input bit hold_res);
        int target;
        int cd;
        int n;
        int w;
        got_q.delete();
        cin_bad  = 0;
        res_n    = -1;
        first_mv = -1;
        last_mv  = -1;
        if (hr_delay == -2) begin
            hash_ready = 1'b1;
            digest_in  = dig;
        end else begin
            hash_ready = 1'b0;
        end
        cmd_len   = len;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            tick();
            w++;
        end
        tick();
        cmd_valid = 1'b0;
        target = (len == 64'd0) ? 1 : int'(len);
        cd = -1;
        n  = 0;
        while (n < 3000) begin
            if (C_in !== len) cin_bad++;
            if (M_valid) begin
                got_q.push_back(M);
                if (first_mv < 0) first_mv = n;
                last_mv = n;
                if (got_q.size() == target && hr_delay >= 0) cd = hr_delay;
            end
            if (cd == 0) begin
                hash_ready = 1'b1;
                digest_in  = dig;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (res_valid) begin
                res_n = n;
                break;
            end
            tick();
            n++;
        end
        r_dig = res_digest;
        r_err = res_err;
        if (!hold_res) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (M_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got=%0h exp=0", M_valid); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got=%0h exp=0", cmd_ready); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid got=%0h exp=0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        n_cmp++; if (C_in !== 64'd0) begin n_bad++; $display("FAIL rst_c_in got=%0h exp=0", C_in); end
        n_cmp++; if ({res_err, res_digest} !== 33'd0) begin n_bad++; $display("FAIL rst_result got=%0h exp=0", {res_err, res_digest}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got=%0h exp=1", in_ready); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_cmd_ready got=%0h exp=1", cmd_ready); end
    endtask

    task automatic test_empty_msg();
        src_q.push_back(8'h41);
        repeat (4) tick();
        run_msg(64'd0, 3, 32'h956F7883, 1'b0);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL empty_strobes got=%0d exp=1", got_q.size()); end
        n_cmp++; if (first_mv !== 1) begin n_bad++; $display("FAIL empty_latency got=%0d exp=1", first_mv); end
        n_cmp++; if (cin_bad !== 0) begin n_bad++; $display("FAIL empty_c_in bad_cycles=%0d exp=0", cin_bad); end
        n_cmp++; if (r_dig !== 32'h956F7883) begin n_bad++; $display("FAIL empty_digest got=%0h exp=956f7883", r_dig); end
        n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL empty_err got=%0h exp=0", r_err); end
    endtask

    task automatic test_one_byte();
        run_msg(64'd1, 3, 32'h2DD99066, 1'b0);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL one_strobes got=%0d exp=1", got_q.size()); end
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== 8'h41) begin n_bad++; $display("FAIL one_byte got=%0h exp=41", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        n_cmp++; if (first_mv !== 1) begin n_bad++; $display("FAIL one_latency got=%0d exp=1", first_mv); end
        n_cmp++; if (cin_bad !== 0) begin n_bad++; $display("FAIL one_c_in bad_cycles=%0d exp=0", cin_bad); end
        n_cmp++; if (r_dig !== 32'h2DD99066) begin n_bad++; $display("FAIL one_digest got=%0h exp=2dd99066", r_dig); end
        hist_ptr += 1;
    endtask

    task automatic test_backpressure();
        int bad;
        logic [31:0] dig;
        dig = $urandom;
        for (int i = 0; i < 156; i++) src_q.push_back(8'(i));
        repeat (30) tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%0h exp=0", in_ready); end
        n_cmp++; if (hist.size() - hist_ptr !== DEPTH) begin n_bad++; $display("FAIL bp_stored got=%0d exp=%0d", hist.size() - hist_ptr, DEPTH); end
        run_msg(64'd156, 2, dig, 1'b0);
        bad = 0;
        for (int i = 0; i < 156; i++) if (i >= got_q.size() || got_q[i] !== 8'(i)) bad++;
        n_cmp++; if (got_q.size() !== 156) begin n_bad++; $display("FAIL bp_strobes got=%0d exp=156", got_q.size()); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_bytes wrong=%0d exp=0", bad); end
        n_cmp++; if (cin_bad !== 0) begin n_bad++; $display("FAIL bp_c_in bad_cycles=%0d exp=0", cin_bad); end
        n_cmp++; if (r_dig !== dig) begin n_bad++; $display("FAIL bp_digest got=%0h exp=%0h", r_dig, dig); end
        t3_q = got_q;
        hist_ptr += 156;
    endtask

    task automatic test_gapped();
        int bad;
        logic [31:0] dig;
        dig = $urandom;
        gap_mode = 1'b1;
        for (int i = 0; i < 156; i++) src_q.push_back(8'(i));
        run_msg(64'd156, 1, dig, 1'b0);
        gap_mode = 1'b0;
        bad = 0;
        for (int i = 0; i < 156; i++) if (i >= got_q.size() || i >= t3_q.size() || got_q[i] !== t3_q[i]) bad++;
        n_cmp++; if (got_q.size() !== 156) begin n_bad++; $display("FAIL gap_strobes got=%0d exp=156", got_q.size()); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL gap_bytes wrong=%0d exp=0", bad); end
        n_cmp++; if (last_mv - first_mv + 1 <= 156) begin n_bad++; $display("FAIL gap_span got=%0d exp>156", last_mv - first_mv + 1); end
        n_cmp++; if (r_dig !== dig) begin n_bad++; $display("FAIL gap_digest got=%0h exp=%0h", r_dig, dig); end
        hist_ptr += 156;
    endtask

    task automatic test_timeout();
        logic [31:0] dig;
        run_msg(64'd0, -1, 32'hDEADBEEF, 1'b0);
        n_cmp++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%0h exp=1", r_err); end
        n_cmp++; if (r_dig !== 32'd0) begin n_bad++; $display("FAIL tmo_digest got=%0h exp=0", r_dig); end
        n_cmp++; if (res_n !== TMO + 4) begin n_bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", res_n, TMO + 4); end
        // Leave hash_ready high, then start a new message with it still high.
        run_msg(64'd0, 0, 32'h11112222, 1'b0);
        n_cmp++; if (r_dig !== 32'h11112222) begin n_bad++; $display("FAIL stale_prev_digest got=%0h exp=11112222", r_dig); end
        src_q.push_back(8'($urandom));
        src_q.push_back(8'($urandom));
        repeat (5) tick();
        dig = $urandom;
        run_msg(64'd2, -2, dig, 1'b0);
        n_cmp++; if (res_n !== 5) begin n_bad++; $display("FAIL stale_guard_cycles got=%0d exp=5", res_n); end
        n_cmp++; if (r_dig !== dig) begin n_bad++; $display("FAIL stale_digest got=%0h exp=%0h", r_dig, dig); end
        n_cmp++; if (got_q.size() !== 2 || got_q[0] !== hist[hist_ptr] || got_q[1] !== hist[hist_ptr + 1]) begin
            n_bad++; $display("FAIL stale_bytes got_n=%0d exp_n=2", got_q.size());
        end
        hist_ptr += 2;
    endtask

    task automatic test_random();
        int len;
        int exp_n;
        int bad;
        int hr;
        logic [31:0] dig;
        for (int k = 0; k < 8; k++) begin
            len      = $urandom_range(0, 40);
            gap_mode = 1'($urandom_range(0, 1));
            hr       = $urandom_range(0, 6);
            dig      = $urandom;
            for (int i = 0; i < len + $urandom_range(0, 3); i++) src_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) tick();
            run_msg(64'(len), hr, dig, 1'b0);
            exp_n = (len == 0) ? 1 : len;
            bad = 0;
            for (int i = 0; i < len; i++)
                if (i >= got_q.size() || hist_ptr + i >= hist.size() || got_q[i] !== hist[hist_ptr + i]) bad++;
            n_cmp++; if (got_q.size() !== exp_n) begin n_bad++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", k, got_q.size(), exp_n); end
            n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rnd%0d_bytes wrong=%0d exp=0", k, bad); end
            n_cmp++; if (cin_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_c_in bad_cycles=%0d exp=0", k, cin_bad); end
            n_cmp++; if ({r_err, r_dig} !== {1'b0, dig}) begin n_bad++; $display("FAIL rnd%0d_result got=%0h exp=%0h", k, {r_err, r_dig}, {1'b0, dig}); end
            hist_ptr += len;
        end
        gap_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        int w;
        int bad;
        logic [31:0] dig;
        for (int i = 0; i < 255; i++) src_q.push_back(8'($urandom));
        hash_ready = 1'b0;
        cmd_len   = 64'd255;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 1000) begin tick(); w++; end
        tick();
        cmd_valid = 1'b0;
        seen = 0;
        w = 0;
        while (seen < 50 && w < 2000) begin
            if (M_valid) seen++;
            if (seen < 50) begin tick(); w++; end
        end
        n_cmp++; if (seen !== 50) begin n_bad++; $display("FAIL mid_progress got=%0d exp=50", seen); end
        rst = 1'b1;
        src_q.delete();
        tick();
        n_cmp++; if ({M_valid, M} !== 9'd0) begin n_bad++; $display("FAIL mid_rst_m got=%0h exp=0", {M_valid, M}); end
        n_cmp++; if (C_in !== 64'd0) begin n_bad++; $display("FAIL mid_rst_c_in got=%0h exp=0", C_in); end
        n_cmp++; if ({cmd_ready, in_ready, res_valid, busy} !== 4'd0) begin n_bad++; $display("FAIL mid_rst_ctrl got=%0b exp=0000", {cmd_ready, in_ready, res_valid, busy}); end
        n_cmp++; if ({res_err, res_digest} !== 33'd0) begin n_bad++; $display("FAIL mid_rst_result got=%0h exp=0", {res_err, res_digest}); end
        rst = 1'b0;
        hist_ptr = 0;
        tick();
        n_cmp++; if ({cmd_ready, in_ready} !== 2'b11) begin n_bad++; $display("FAIL mid_post_ready got=%0b exp=11", {cmd_ready, in_ready}); end
        src_q.push_back(8'h5A);
        repeat (4) tick();
        dig = $urandom;
        run_msg(64'd1, 3, dig, 1'b1);
        n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin n_bad++; $display("FAIL mid_new_byte got_n=%0d exp 5a", got_q.size()); end
        n_cmp++; if ({r_err, r_dig} !== {1'b0, dig}) begin n_bad++; $display("FAIL mid_new_result got=%0h exp=%0h", {r_err, r_dig}, {1'b0, dig}); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_digest !== dig) bad++;
            tick();
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL mid_hold_result bad_cycles=%0d exp=0", bad); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if ({busy, res_valid, cmd_ready} !== 3'b001) begin n_bad++; $display("FAIL mid_release got=%0b exp=001", {busy, res_valid, cmd_ready}); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = 64'd0;
        hash_ready = 1'b0;
        digest_in  = 32'd0;
        res_ready  = 1'b0;
        test_reset();
        test_empty_msg();
        test_one_byte();
        test_backpressure();
        test_gapped();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
